// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed memory responder with wait-stated byte and word accesses
module mem_responder #(
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = "memory.txt"
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req,
  input  logic        rw,
  input  logic        wb,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mdr_out,
  output logic        busy,
  output logic        done,
  input  logic [15:0] dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  logic [7:0]  mem [65536];
  state_t      state;
  logic [3:0]  wcnt;
  logic        rw_q;
  logic        wb_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;

  logic        access;
  logic        we;
  logic [15:0] addr_inc;
  logic [15:0] acc_addr;
  logic [7:0]  wr_byte;
  logic [15:0] dbg_inc;

  // the last wait cycle of a byte phase is the one that touches the array
  assign access   = (state == LO || state == HI) && (wcnt == WS);
  assign addr_inc = addr_q + 16'd1;
  assign acc_addr = (state == HI) ? addr_inc : addr_q;
  assign wr_byte  = (state == HI) ? data_q[15:8] : data_q[7:0];
  assign we       = access && rw_q && !Reset;

  assign dbg_inc  = dbg_addr + 16'd1;
  assign dbg_data = {mem[dbg_inc], mem[dbg_addr]};

  always_ff @(posedge Clock) begin
    if (we) mem[acc_addr] <= wr_byte;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mdr_out <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            rw_q   <= rw;
            wb_q   <= wb;
            addr_q <= mar;
            data_q <= mdr_in;
            wcnt   <= 4'd0;
            busy   <= 1'b1;
            state  <= LO;
          end else begin
            busy <= 1'b0;
          end
        end
        LO: begin
          if (!access) begin
            wcnt <= wcnt + 4'd1;
          end else begin
            if (!rw_q) begin
              mdr_out[7:0] <= mem[addr_q];
              if (wb_q) mdr_out[15:8] <= 8'h00;
            end
            wcnt <= 4'd0;
            if (wb_q) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= HI;
            end
          end
        end
        HI: begin
          if (!access) begin
            wcnt <= wcnt + 4'd1;
          end else begin
            if (!rw_q) mdr_out[15:8] <= mem[addr_inc];
            wcnt  <= 4'd0;
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder at WAIT_STATES 1 and 0
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req      [2];
  logic        rw       [2];
  logic        wb       [2];
  logic [15:0] mar      [2];
  logic [15:0] mdr_in   [2];
  logic [15:0] mdr_out  [2];
  logic        busy     [2];
  logic        done     [2];
  logic [15:0] dbg_addr [2];
  logic [15:0] dbg_data [2];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(1), .INIT_FILE("")) u_dut_w1 (
    .Clock(clk), .Reset(rst), .req(req[0]), .rw(rw[0]), .wb(wb[0]), .mar(mar[0]),
    .mdr_in(mdr_in[0]), .mdr_out(mdr_out[0]), .busy(busy[0]), .done(done[0]),
    .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
  );

  mem_responder #(.WAIT_STATES(0), .INIT_FILE("")) u_dut_w0 (
    .Clock(clk), .Reset(rst), .req(req[1]), .rw(rw[1]), .wb(wb[1]), .mar(mar[1]),
    .mdr_in(mdr_in[1]), .mdr_out(mdr_out[1]), .busy(busy[1]), .done(done[1]),
    .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
  );

  typedef struct {
    string       tag;
    int          lat;
    logic [15:0] mdr;
  } exp_t;

  exp_t        sb [$];
  int          done_idx [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last_mdr [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input int u, input string tag, input logic w, input logic b,
                        input logic [15:0] a, input logic [15:0] d, input int lat,
                        input logic [15:0] rd);
    exp_t e;
    int   n;
    logic busy_ok;
    if (!w) last_mdr[u] = rd;
    e.tag = tag;
    e.lat = lat;
    e.mdr = last_mdr[u];
    sb.push_back(e);
    @(negedge clk);
    req[u] = 1'b1; rw[u] = w; wb[u] = b; mar[u] = a; mdr_in[u] = d;
    @(negedge clk);
    req[u] = 1'b0; rw[u] = ~w; wb[u] = ~b; mar[u] = ~a; mdr_in[u] = 16'($urandom);
    n = 1;
    busy_ok = 1'b1;
    while (done[u] !== 1'b1 && n < 40) begin
      if (busy[u] !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (busy[u] !== 1'b1) busy_ok = 1'b0;
    e = sb.pop_front();
    check({e.tag, " latency"}, n, e.lat);
    check({e.tag, " mdr_out"}, mdr_out[u], e.mdr);
    check({e.tag, " busy"}, busy_ok, 1);
    @(negedge clk);
    check({e.tag, " idle"}, {busy[u], done[u]}, 0);
  endtask

  task automatic peek(input int u, input string tag, input logic [15:0] a, input logic [15:0] exp);
    dbg_addr[u] = a;
    #1;
    check(tag, dbg_data[u], exp);
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; rw[u] = 1'b0; wb[u] = 1'b0;
      mar[u] = 16'h0; mdr_in[u] = 16'h0; dbg_addr[u] = 16'h0;
      last_mdr[u] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset w1", {busy[0], done[0], mdr_out[0]}, 0);
    check("reset w0", {busy[1], done[1], mdr_out[1]}, 0);
    rst = 1'b0;

    access(0, "w1 wr 0100",     1, 0, 16'h0100, 16'h1234, 5, 16'h0);
    access(0, "w1 rd 0100",     0, 0, 16'h0100, 16'h0000, 5, 16'h1234);
    access(0, "w1 wr 0200",     1, 0, 16'h0200, 16'h5555, 5, 16'h0);
    access(0, "w1 bwr 0200",    1, 1, 16'h0200, 16'hABCD, 3, 16'h0);
    peek(0, "dbg 0200", 16'h0200, 16'h55CD);
    access(0, "w1 brd 0200",    0, 1, 16'h0200, 16'h0000, 3, 16'h00CD);
    access(0, "w1 wr ffff",     1, 0, 16'hFFFF, 16'hBEEF, 5, 16'h0);
    peek(0, "dbg ffff wrap", 16'hFFFF, 16'hBEEF);
    access(0, "w1 rd ffff",     0, 0, 16'hFFFF, 16'h0000, 5, 16'hBEEF);

    // level-held req: FIN, one idle cycle, then the next accept
    done_idx.push_back(5); done_idx.push_back(11); done_idx.push_back(17);
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; wb[0] = 1'b0; mar[0] = 16'h0100;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) begin
        if (done_idx.size() > 0) check("held done cycle", k, done_idx.pop_front());
        else check("held extra done", k, 0);
        check("held mdr_out", mdr_out[0], 16'h1234);
      end
      if (k == 6 || k == 12) check("held idle gap", busy[0], 0);
    end
    req[0] = 1'b0;
    check("held dones left", done_idx.size(), 0);
    @(negedge clk);
    check("held end idle", {busy[0], done[0]}, 0);
    last_mdr[0] = 16'h1234;

    access(1, "w0 wr 0100",  1, 0, 16'h0100, 16'h12FF, 3, 16'h0);
    access(1, "w0 rd 0100",  0, 0, 16'h0100, 16'h0000, 3, 16'h12FF);
    access(1, "w0 brd 0101", 0, 1, 16'h0101, 16'h0000, 2, 16'h0012);

    // reset lands on the high-byte access edge of a word write
    access(0, "w1 wr 0300",  1, 0, 16'h0300, 16'h1111, 5, 16'h0);
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; wb[0] = 1'b0; mar[0] = 16'h0300; mdr_in[0] = 16'h5678;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", busy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post-reset w1", {busy[0], done[0], mdr_out[0]}, 0);
    check("post-reset w0 mdr", mdr_out[1], 16'h0000);
    peek(0, "dbg 0300 partial", 16'h0300, 16'h1178);
    repeat (2) @(negedge clk);
    check("post-reset idle", {busy[0], done[0]}, 0);
    peek(0, "dbg 0300 kept", 16'h0300, 16'h1178);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
